if_pc_reg: RTL and testbench

- IF-stage program-counter register. Consumes the next-PC value produced by the combinational next-PC selector and presents the current fetch address to instruction memory.
- Also owns the other fetch-side sequential concerns:
  - stall hold;
  - exception and ERET redirection;
  - branch-delay-slot tagging;
  - fetch address-error detection;
  - halt detection when the next-PC selector parks on the termination address.
- Outputs travel with the fetched instruction into the IF/ID pipeline register.

---
 rtl/if_pc_reg.sv | 114 +++++++++++
 tb/tb_if_pc_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_pc_reg.sv
// if_pc_reg: IF-stage PC register with stall, redirect, delay-slot tag,
// fetch AdEL check and halt detect. Define IF_FETCH_COUNT_EN for fetchCount.
module if_pc_reg #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] TEXT_END  = 32'h0000_6FFC,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] HALT_ADDR = 32'h0000_417C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] npc,
  input  logic        isBranchJump,
  input  logic        excReq,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] PC,
  output logic        fetchValid,
  output logic        bd,
  output logic        excAdEL,
  output logic        halted
`ifdef IF_FETCH_COUNT_EN
  ,
  output logic [31:0] fetchCount
`endif
);

  localparam logic [31:0] KTEXT_END = 32'h0000_4FFC;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic [31:0] r_pc;
  logic [31:0] w_pc_n;
  logic        r_bd;
  logic        w_bd_n;
  logic        w_kernel;
  logic        w_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
      r_pc    <= PC_RESET;
      r_bd    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_bd    <= w_bd_n;
    end
  end

  // excReq outranks everything, including HALT; eret cannot leave HALT
  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_bd_n    = r_bd;
    if (excReq) begin
      w_state_n = S_FLUSH;
      w_pc_n    = EXC_ENTRY;
      w_bd_n    = 1'b0;
    end else if (r_state != S_HALT) begin
      if (eret) begin
        w_state_n = S_FLUSH;
        w_pc_n    = epc;
        w_bd_n    = 1'b0;
      end else if (en) begin
        w_pc_n = npc;
        if (r_state == S_RUN) begin
          w_bd_n = isBranchJump;
          if (npc == HALT_ADDR) begin
            w_state_n = S_HALT;
          end
        end else begin
          w_bd_n    = 1'b0;
          w_state_n = S_RUN;
        end
      end
    end
  end

  assign w_kernel = (r_pc >= HALT_ADDR) && (r_pc <= KTEXT_END);
  assign w_bad    = (r_pc[1:0] != 2'b00) ||
                    (r_pc < PC_RESET) ||
                    (r_pc > TEXT_END);

  assign PC         = r_pc;
  assign bd         = r_bd;
  assign fetchValid = (r_state != S_FLUSH);
  assign halted     = (r_state == S_HALT);
  assign excAdEL    = w_bad && !w_kernel;

`ifdef IF_FETCH_COUNT_EN
  logic [31:0] r_cnt;
  logic        w_cnt_inc;

  assign w_cnt_inc = (r_state == S_RUN) && en && !excReq && !eret;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 32'd0;
    end else if (w_cnt_inc && (r_cnt != 32'hFFFF_FFFF)) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign fetchCount = r_cnt;
`endif

endmodule

// File: tb/tb_if_pc_reg.sv
// tb_if_pc_reg: scoreboarded random + directed test of if_pc_reg
// against a rule-level fetch model.
module tb_if_pc_reg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] TEXT_END  = 32'h0000_6FFC;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] HALT_ADDR = 32'h0000_417C;

  localparam int M_RUN   = 0;
  localparam int M_FLUSH = 1;
  localparam int M_HALT  = 2;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] npc;
  logic        isBranchJump;
  logic        excReq;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] PC;
  logic        fetchValid;
  logic        bd;
  logic        excAdEL;
  logic        halted;
`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetchCount;
`endif

  if_pc_reg dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .npc          (npc),
    .isBranchJump (isBranchJump),
    .excReq       (excReq),
    .eret         (eret),
    .epc          (epc),
    .PC           (PC),
    .fetchValid   (fetchValid),
    .bd           (bd),
    .excAdEL      (excAdEL),
    .halted       (halted)
`ifdef IF_FETCH_COUNT_EN
    ,
    .fetchCount   (fetchCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        bd;
    logic        adel;
    logic        hlt;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  int          m_mode;
  logic        m_bd;
  logic [31:0] m_cnt;

  function automatic logic adel_of(input logic [31:0] a);
    if (a >= HALT_ADDR && a <= 32'h0000_4FFC) return 1'b0;
    return (a % 4 != 0) || (a < PC_RESET) || (a > TEXT_END);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.pc   = m_pc;
    e.fv   = (m_mode != M_FLUSH);
    e.bd   = m_bd;
    e.adel = adel_of(m_pc);
    e.hlt  = (m_mode == M_HALT);
    e.cnt  = m_cnt;
    return e;
  endfunction

  task automatic model_reset();
    m_pc   = PC_RESET;
    m_mode = M_RUN;
    m_bd   = 1'b0;
    m_cnt  = 32'd0;
  endtask

  task automatic check_now(input string tag, input exp_t e);
    chk({tag, ".PC"}, PC, e.pc);
    chk({tag, ".fetchValid"}, {31'd0, fetchValid}, {31'd0, e.fv});
    chk({tag, ".bd"}, {31'd0, bd}, {31'd0, e.bd});
    chk({tag, ".excAdEL"}, {31'd0, excAdEL}, {31'd0, e.adel});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e.hlt});
`ifdef IF_FETCH_COUNT_EN
    chk({tag, ".fetchCount"}, fetchCount, e.cnt);
`endif
  endtask

  // one clock of stimulus; the model predicts the post-edge outputs
  task automatic step(input logic e, input logic [31:0] n, input logic bj,
                      input logic x, input logic r, input logic [31:0] ep);
    @(negedge clk);
    en = e; npc = n; isBranchJump = bj;
    excReq = x; eret = r; epc = ep;
    if (x) begin
      m_pc = EXC_ENTRY; m_bd = 1'b0; m_mode = M_FLUSH;
    end else if (m_mode == M_HALT) begin
    end else if (r) begin
      m_pc = ep; m_bd = 1'b0; m_mode = M_FLUSH;
    end else if (!e) begin
    end else if (m_mode == M_RUN) begin
      m_pc = n; m_bd = bj;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (n == HALT_ADDR) m_mode = M_HALT;
    end else begin
      m_pc = n; m_bd = 1'b0; m_mode = M_RUN;
    end
    q.push_back(snap());
  endtask

  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) check_now("mon", q.pop_front());
  end

  function automatic logic [31:0] rnd_addr(input int mode);
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return $urandom;
    if (k == 1 && mode == M_RUN) return HALT_ADDR;
    return PC_RESET + 32'($urandom_range(0, 32'hFFF)) * 4;
  endfunction

  initial begin
    reset = 1'b1; en = 1'b0; npc = '0; isBranchJump = 1'b0;
    excReq = 1'b0; eret = 1'b0; epc = '0;
    model_reset();
    #3;
    check_now("reset", snap());
    @(negedge clk);
    reset = 1'b0;

    step(1, 32'h3004, 0, 0, 0, 0);
    step(1, 32'h3008, 0, 0, 0, 0);
    step(0, 32'h300C, 0, 0, 0, 0);
    step(0, 32'h300C, 0, 0, 0, 0);
    step(1, 32'h300C, 0, 0, 0, 0);
    step(1, 32'h3010, 0, 0, 0, 0);
    step(1, 32'h3014, 1, 0, 0, 0);
    step(1, 32'h3018, 0, 0, 0, 0);
    step(0, 32'h301C, 0, 1, 1, 32'h3200);
    step(1, 32'h3020, 0, 0, 0, 0);
    step(1, 32'h2FFE, 0, 0, 0, 0);
    step(1, 32'h3000, 0, 0, 0, 0);
    step(1, HALT_ADDR, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      step($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
           0, $urandom_range(0, 1), $urandom);
    step(1, 32'h3040, 0, 1, 0, 0);
    step(1, 32'h3100, 0, 0, 0, 0);
    step(1, 32'h3104, 0, 0, 1, 32'h3300);

    // asynchronous reset pulse inside the FLUSH cycle
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_now("async_rst", snap());
    #1 reset = 1'b0;

    step(1, 32'h3004, 0, 0, 0, 0);
    step(1, 32'h3008, 0, 0, 0, 0);
    step(0, 32'h300C, 0, 0, 0, 0);
    step(1, 32'h300C, 0, 0, 0, 0);
    step(0, 32'h3010, 0, 0, 0, 0);
    step(1, 32'h3010, 0, 0, 0, 0);
    step(1, 32'h3014, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic x, r, e;
      x = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 3) != 0);
      step(e, rnd_addr(m_mode), $urandom_range(0, 1), x, r,
           rnd_addr(M_FLUSH));
    end

    @(posedge clk);
    #2;
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
